// File: rtl/uart_cmd_link.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_link
// Description : UART link to a host. The receiver assembles two consecutive
//               valid bytes into a 16-bit command (first byte high) and flags
//               it with cmd_rdy. The transmitter sends one response byte per
//               accepted send_resp pulse and reports completion on resp_sent.
//               Frame: 1 start (0), 8 data LSB first, 1 stop (1), no parity.
// Ports       : clk, rst_n (async, active-low)
//               RX          serial in from host, idle high, asynchronous
//               TX          serial out to host, idle high
//               cmd[15:0]   assembled command
//               cmd_rdy     cmd holds a complete command (level)
//               clr_cmd_rdy pulse, clears cmd_rdy
//               resp[7:0]   response byte, sampled with send_resp
//               send_resp   pulse, starts a response frame when idle
//               resp_sent   last response frame fully shifted out (level)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_link #(
    parameter int BAUD_DIV = 1736
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [15:0] c_bit_last  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_half_last = 16'((BAUD_DIV / 2) - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic c_tx_idle  = 1'b0;
    localparam logic c_tx_shift = 1'b1;

    // ------------------------------------------------------------------------
    // RX synchronizer (preset high so reset looks like an idle line)
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------------
    logic [1:0]  r_rx_state;
    logic [1:0]  w_rx_state_nxt;
    logic [15:0] r_rx_cnt;
    logic [15:0] w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit_idx;
    logic [7:0]  r_rx_shift;
    logic        w_rx_sample;
    logic        w_rx_stop;
    logic        w_rx_valid;
    logic        w_rx_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= c_rx_idle;
            r_rx_cnt   <= 16'd0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 16'd1;
        w_rx_sample    = 1'b0;
        w_rx_stop      = 1'b0;
        case (r_rx_state)
            c_rx_idle: begin
                w_rx_cnt_nxt = 16'd0;
                if (!r_rx_sync) begin
                    w_rx_state_nxt = c_rx_start;
                end
            end
            c_rx_start: begin
                // Mid start bit: a line already back high was a glitch.
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt   = 16'd0;
                    w_rx_state_nxt = r_rx_sync ? c_rx_idle : c_rx_data;
                end
            end
            c_rx_data: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt = 16'd0;
                    w_rx_sample  = 1'b1;
                    if (r_rx_bit_idx == 3'd7) begin
                        w_rx_state_nxt = c_rx_stop;
                    end
                end
            end
            c_rx_stop: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = 16'd0;
                    w_rx_stop      = 1'b1;
                    w_rx_state_nxt = c_rx_idle;
                end
            end
            default: begin
                w_rx_cnt_nxt   = 16'd0;
                w_rx_state_nxt = c_rx_idle;
            end
        endcase
    end

    assign w_rx_valid     = w_rx_stop & r_rx_sync;
    assign w_rx_frame_err = w_rx_stop & ~r_rx_sync;

    // Data bits arrive LSB first, so shift in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_bit_idx <= 3'd0;
            r_rx_shift   <= 8'd0;
        end else begin
            if (w_rx_sample) begin
                r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                r_rx_shift   <= {r_rx_sync, r_rx_shift[7:1]};
            end else if (r_rx_state != c_rx_data) begin
                r_rx_bit_idx <= 3'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command assembly. r_ptr_low=0 means the next byte is the high byte.
    // ------------------------------------------------------------------------
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        r_ptr_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
            r_ptr_low <= 1'b0;
        end else begin
            if (w_rx_frame_err) begin
                r_ptr_low <= 1'b0;
            end else if (w_rx_valid && !r_cmd_rdy) begin
                if (!r_ptr_low) begin
                    r_cmd[15:8] <= r_rx_shift;
                    r_ptr_low   <= 1'b1;
                end else begin
                    r_cmd[7:0]  <= r_rx_shift;
                    r_ptr_low   <= 1'b0;
                end
            end

            // A completed command takes priority over a stale clear.
            if (w_rx_valid && !r_cmd_rdy && r_ptr_low) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // ------------------------------------------------------------------------
    // Transmitter FSM
    // ------------------------------------------------------------------------
    logic        r_tx_state;
    logic        w_tx_state_nxt;
    logic [15:0] r_tx_cnt;
    logic [15:0] w_tx_cnt_nxt;
    logic [3:0]  r_tx_bits;
    logic [9:0]  r_tx_shift;
    logic        r_resp_sent;
    logic        w_tx_load;
    logic        w_tx_shift_en;
    logic        w_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= c_tx_idle;
            r_tx_cnt   <= 16'd0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 16'd1;
        w_tx_load      = 1'b0;
        w_tx_shift_en  = 1'b0;
        w_tx_done      = 1'b0;
        case (r_tx_state)
            c_tx_idle: begin
                w_tx_cnt_nxt = 16'd0;
                if (send_resp) begin
                    w_tx_load      = 1'b1;
                    w_tx_state_nxt = c_tx_shift;
                end
            end
            c_tx_shift: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_nxt = 16'd0;
                    if (r_tx_bits == 4'd9) begin
                        w_tx_done      = 1'b1;
                        w_tx_state_nxt = c_tx_idle;
                    end else begin
                        w_tx_shift_en = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_cnt_nxt   = 16'd0;
                w_tx_state_nxt = c_tx_idle;
            end
        endcase
    end

    // Ones shift in from the top so TX stays at the idle level afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift  <= 10'h3FF;
            r_tx_bits   <= 4'd0;
            r_resp_sent <= 1'b0;
        end else begin
            if (w_tx_load) begin
                r_tx_shift  <= {1'b1, resp, 1'b0};
                r_tx_bits   <= 4'd0;
                r_resp_sent <= 1'b0;
            end else if (w_tx_shift_en) begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
            end else if (w_tx_done) begin
                r_tx_shift  <= 10'h3FF;
                r_resp_sent <= 1'b1;
            end
        end
    end

    assign TX        = r_tx_shift[0];
    assign resp_sent = r_resp_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_link
// Description : Self-checking bench for uart_cmd_link. A command-level model
//               (byte pointer, ready flag, expected command word) predicts the
//               receiver; transmitted frames are compared bit by bit against
//               the expected start/data/stop pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_link;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [15:0] exp_cmd = 16'h0000;
    logic        exp_rdy = 1'b0;
    logic        exp_ptr_low = 1'b0;

    uart_cmd_link #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one frame on RX, followed by one bit time of idle.
    task automatic rx_drive(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(posedge clk);
            #1;
        end
        RX = 1'b1;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic model_rx(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            exp_ptr_low = 1'b0;
        end else if (!exp_rdy) begin
            if (!exp_ptr_low) begin
                exp_cmd[15:8] = b;
                exp_ptr_low   = 1'b1;
            end else begin
                exp_cmd[7:0]  = b;
                exp_ptr_low   = 1'b0;
                exp_rdy       = 1'b1;
            end
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop_ok);
        rx_drive(b, stop_ok);
        model_rx(b, stop_ok);
        check_value("rx_cmd", cmd, exp_cmd);
        check_value("rx_rdy", cmd_rdy, exp_rdy);
    endtask

    task automatic clr_pulse();
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check_value("clr_rdy", cmd_rdy, exp_rdy);
        check_value("clr_cmd", cmd, exp_cmd);
    endtask

    // Send one response and compare each bit at its centre. With poke set, a
    // second send_resp with different data is issued during bit 3.
    task automatic tx_frame(input logic [7:0] r, input bit poke);
        logic [9:0] f;
        f = {1'b1, r, 1'b0};
        resp = r;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        resp = 8'($urandom);
        check_value("tx_sent_clr", resp_sent, 1'b0);
        check_value("tx_start_now", TX, 1'b0);
        repeat (B / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check_value($sformatf("tx_bit%0d", i), TX, f[i]);
            check_value("tx_sent_busy", resp_sent, 1'b0);
            if (i < 9) begin
                if (poke && i == 3) begin
                    resp = ~r;
                    send_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    send_resp = 1'b0;
                    repeat (B - 1) @(posedge clk);
                end else begin
                    repeat (B) @(posedge clk);
                end
                #1;
            end
        end
        repeat (B / 2 - 1) @(posedge clk);
        #1;
        check_value("tx_sent_early", resp_sent, 1'b0);
        @(posedge clk);
        #1;
        check_value("tx_sent_set", resp_sent, 1'b1);
        check_value("tx_idle", TX, 1'b1);
    endtask

    task automatic false_start();
        RX = 1'b0;
        repeat (B / 4) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        check_value("glitch_cmd", cmd, exp_cmd);
        check_value("glitch_rdy", cmd_rdy, exp_rdy);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] tb;
        int act;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_tx", TX, 1'b1);
        check_value("rst_cmd", cmd, 16'h0000);
        check_value("rst_rdy", cmd_rdy, 1'b0);
        check_value("rst_sent", resp_sent, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Basic command and clear
        rx_byte(8'h46, 1'b1);
        rx_byte(8'h2A, 1'b1);
        check_value("cmd_462A", cmd, 16'h462A);
        clr_pulse();

        // Response 0xA5, then a second response clears resp_sent
        tx_frame(8'hA5, 1'b0);
        tx_frame(8'h3C, 1'b1);

        // Framing error discards the byte and resets the pointer
        rx_byte(8'h12, 1'b0);
        rx_byte(8'h34, 1'b1);
        rx_byte(8'h56, 1'b1);
        check_value("cmd_3456", cmd, 16'h3456);

        // Byte ignored while cmd_rdy is set
        rx_byte(8'h99, 1'b1);
        clr_pulse();
        rx_byte(8'h01, 1'b1);
        rx_byte(8'h02, 1'b1);
        check_value("cmd_0102", cmd, 16'h0102);
        clr_pulse();

        // Short low pulse is rejected; pointer unaffected
        false_start();
        rx_byte(8'hBE, 1'b1);
        false_start();
        rx_byte(8'hEF, 1'b1);
        check_value("cmd_BEEF", cmd, 16'hBEEF);
        clr_pulse();

        // Concurrent RX and TX
        fork
            tx_frame(8'h5E, 1'b0);
            begin
                rx_byte(8'hC0, 1'b1);
                rx_byte(8'hDE, 1'b1);
            end
        join
        clr_pulse();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 9);
            rb  = 8'($urandom);
            tb  = 8'($urandom);
            case (act)
                0, 1, 2, 3, 4: rx_byte(rb, 1'b1);
                5:             rx_byte(rb, 1'b0);
                6:             clr_pulse();
                7:             tx_frame(tb, 1'($urandom_range(0, 1)));
                8:             false_start();
                default: begin
                    fork
                        tx_frame(tb, 1'b0);
                        rx_byte(rb, 1'b1);
                    join
                end
            endcase
        end

        // Reset during TX bit 4 and RX bit 5
        fork
            rx_drive(8'hE0, 1'b1);
        join_none
        repeat (24) @(posedge clk);
        #1;
        resp = 8'h5A;
        send_resp = 1'b1;
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        repeat (65) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_tx", TX, 1'b1);
        check_value("mid_rst_cmd", cmd, 16'h0000);
        check_value("mid_rst_rdy", cmd_rdy, 1'b0);
        check_value("mid_rst_sent", resp_sent, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cmd = 16'h0000;
        exp_rdy = 1'b0;
        exp_ptr_low = 1'b0;
        repeat (90) @(posedge clk);
        #1;
        check_value("post_rst_cmd", cmd, 16'h0000);
        check_value("post_rst_rdy", cmd_rdy, 1'b0);
        check_value("post_rst_tx", TX, 1'b1);
        check_value("post_rst_sent", resp_sent, 1'b0);
        rx_byte(8'h7E, 1'b1);
        rx_byte(8'hC3, 1'b1);
        check_value("cmd_7EC3", cmd, 16'h7EC3);
        clr_pulse();
        tx_frame(8'h81, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_link.md
UART_CMD_LINK -- requirements
Module: uart_cmd_link

Interface
REQ-001 Parameter BAUD_DIV, default 1736, sets clk cycles per UART bit (57600 baud).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 RX  input  1  serial line from host, idle high, asynchronous to clk.
REQ-005 TX  output  1  serial line to host, idle high.
REQ-006 cmd  output  16  assembled command; first received byte is cmd[15:8], second is cmd[7:0].
REQ-007 cmd_rdy  output  1  level; cmd holds a complete command.
REQ-008 clr_cmd_rdy  input  1  one-cycle pulse from the command processor; clears cmd_rdy.
REQ-009 resp  input  8  response byte; sampled only when send_resp=1.
REQ-010 send_resp  input  1  one-cycle pulse; start transmission of resp.
REQ-011 resp_sent  output  1  level; last response frame fully shifted out.

Function
REQ-012 UART frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity, each bit BAUD_DIV cycles.
REQ-013 RX SHALL pass through a 2-flop synchronizer, preset to 1 on reset, before any use.
REQ-014 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized RX=0.
REQ-016 START: at BAUD_DIV/2 cycles, if RX=1 then false start, return to IDLE; else go to DATA.
REQ-017 DATA: sample RX every BAUD_DIV cycles, at bit centre, 8 times.
REQ-018 STOP: sample RX one BAUD_DIV later; RX=1 means a valid byte, RX=0 means a framing error; in both cases return to IDLE.
REQ-019 A framing error SHALL discard the byte and reset the byte pointer to the high byte.
REQ-020 On a valid byte, pointer=high: load cmd[15:8] and set pointer=low.
REQ-021 On a valid byte, pointer=low: load cmd[7:0], set pointer=high, and set cmd_rdy the next cycle.
REQ-022 While cmd_rdy=1, valid bytes SHALL be discarded, leaving cmd and the pointer unchanged.
REQ-023 clr_cmd_rdy=1 SHALL clear cmd_rdy the next cycle; cmd keeps its value.
REQ-024 Transmitter states SHALL be IDLE and SHIFT; a 10-bit shift register is loaded with {1, resp, 0} and shifted LSB first onto TX.
REQ-025 send_resp in IDLE SHALL latch resp, clear resp_sent, and enter SHIFT; TX drives the start bit from the next cycle.
REQ-026 SHIFT SHALL hold each bit for exactly BAUD_DIV cycles, for 10 bits in total.
REQ-027 After the stop bit period, the transmitter SHALL return to IDLE and set resp_sent=1, held until the next accepted send_resp.
REQ-028 send_resp during SHIFT SHALL be ignored: no relatch and no effect on resp_sent.
REQ-029 Receiver and transmitter SHALL operate independently; simultaneous RX activity and TX shifting is legal.
REQ-030 Baud counters SHALL be 16 bits; they reset to 0 on every state entry.

Reset
REQ-031 On rst_n=0, immediately: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, both FSMs IDLE, pointer=high, counters 0, shift register all ones.
REQ-032 Reset mid-frame SHALL abort any RX assembly or TX frame without completing it.
REQ-033 After reset release, a partially observed RX frame SHALL be treated as a new start only on a fresh RX=0 seen in IDLE.

Verification
REQ-034 Host sends bytes 0x46, 0x2A -> cmd=16'h462A, cmd_rdy=1; clr_cmd_rdy pulse -> cmd_rdy=0 next cycle, cmd unchanged.
REQ-035 send_resp with resp=0xA5 -> TX shows 0,1,0,1,0,0,1,0,1,1, each BAUD_DIV cycles; resp_sent=1 after bit 10; the next send_resp clears resp_sent.
REQ-036 Byte 0x12 with stop bit 0, then 0x34, 0x56 -> cmd=16'h3456; 0x12 is never seen on cmd.
REQ-037 With cmd_rdy=1, host sends 0x99 -> cmd and cmd_rdy unchanged; after clr, next bytes 0x01, 0x02 -> cmd=16'h0102.
REQ-038 RX low pulse of BAUD_DIV/4 cycles -> no byte accepted, receiver back in IDLE.
REQ-039 rst_n asserted during TX bit 4 and RX bit 5 -> TX=1, cmd=0, cmd_rdy=0, resp_sent=0 immediately; a following clean exchange works.
